gray_to_binary_serial: RTL and testbench

//   Bit-serial Gray-to-binary decoder: the inverse of the team's binary-to-Gray converter.

---
 rtl/gray_to_binary_serial.sv | 122 ++++++++++++
 tb/tb_gray_to_binary_serial.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_serial.sv
// Bit-serial Gray-to-binary decoder: latches one Gray word, resolves one binary bit
// per clock from MSB to LSB, then holds the result on a valid/ready output.
module gray_to_binary_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             busy
);

    localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_START = (WIDTH > 1) ? (WIDTH - 2) : 0;
    // The Gray MSB feeds b_r directly at accept, so only the lower bits are kept.
    localparam int G_W       = (WIDTH > 1) ? (WIDTH - 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [G_W-1:0]     g_r;
    logic [WIDTH-1:0]   b_r;
    logic [IDX_W-1:0]   idx_r;
    logic               accept_s;

    assign accept_s = (state_r == ST_IDLE) && in_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state_s = (WIDTH == 1) ? ST_DONE : ST_CONV;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (idx_r == {IDX_W{1'b0}}) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath: latch the word on accept, then resolve one bit per edge in CONV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_r   <= {G_W{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            g_r            <= g_in[G_W-1:0];
            b_r            <= {WIDTH{1'b0}};
            b_r[WIDTH-1]   <= g_in[WIDTH-1];
            idx_r          <= IDX_W'(IDX_START);
        end else if (state_r == ST_CONV) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (idx_r == IDX_W'(i)) begin
                    b_r[i] <= b_r[i+1] ^ g_r[i];
                end
            end
            if (idx_r != {IDX_W{1'b0}}) begin
                idx_r <= idx_r - IDX_W'(1);
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        b_out     = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_CONV: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                b_out     = b_r;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Self-checking bench for gray_to_binary_serial (WIDTH=4): directed scenarios plus a
// randomized round-trip against a prefix-XOR reference model and an in-order scoreboard.
module tb_gray_to_binary_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] g_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] b_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    gray_to_binary_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] g);
        @(negedge clk);
        g_in     = g;
        in_valid = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        g_in     = W'($urandom);
    endtask

    // Counts negedges after the accept edge until out_valid; bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic take(input string tag, input logic [W-1:0] exp);
        check(tag, 32'(b_out), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_xfer_valid", 32'(out_valid), 32'd0);
        check("post_xfer_ready", 32'(in_ready), 32'd1);
    endtask

    logic [W-1:0] dir_g [3];
    logic [W-1:0] perm [16];
    logic [W-1:0] exp_q [$];
    int lat;
    int sent;
    int rcvd;

    initial begin
        dir_g[0] = 4'b0000; dir_g[1] = 4'b1110; dir_g[2] = 4'b0100;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed decodes and latency.
        for (int i = 0; i < 3; i++) begin
            send(dir_g[i]);
            wait_out(lat);
            check("dir_latency", 32'(lat), 32'(W - 1));
            check("dir_busy", 32'(busy), 32'd1);
            take("dir_decode", ref_decode(dir_g[i]));
        end
        check("model_all_zero", 32'(ref_decode(dir_g[0])), 32'd0);

        // Backpressure: result held with in_ready low.
        send(4'b1000);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_b_out", 32'(b_out), 32'(4'b1111));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        take("bp_decode", 4'b1111);

        // Busy-ignore: in_valid pulse and g_in changes during CONV.
        send(4'b0110);
        @(negedge clk);
        check("conv_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; g_in = 4'b1111;
        @(negedge clk);
        in_valid = 1'b0; g_in = 4'b0000;
        wait_out(lat);
        take("ignore_decode", ref_decode(4'b0110));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ignore_no_extra", 32'(out_valid), 32'd0);
        end

        // Async reset while DONE: out_valid drops without a clock edge.
        send(4'b0011);
        wait_out(lat);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_b_out", 32'(b_out), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-CONV discards the word.
        send(4'b1110);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("midconv_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("midconv_in_ready", 32'(in_ready), 32'd1);
        send(4'b0100);
        wait_out(lat);
        take("midconv_next", 4'b0111);

        // Round-trip over all 16 values in shuffled order, random out_ready, in_valid held high.
        for (int i = 0; i < 16; i++) perm[i] = W'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [W-1:0] t;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 2000 && rcvd < 16; cyc++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (out_valid) begin
                out_ready = 1'($urandom);
                if (out_ready) begin
                    check("rt_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("rt_decode", 32'(b_out), 32'(exp_q.pop_front()));
                    rcvd++;
                end
            end
            if (sent < 16) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    g_in = perm[sent] ^ (perm[sent] >> 1);
                    exp_q.push_back(ref_decode(g_in));
                    check("rt_model", 32'(ref_decode(g_in)), 32'(perm[sent]));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("rt_received", 32'(rcvd), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
